// File: rtl/risc_toy_ifetch.sv
// RISC_TOY instruction fetch: issues word fetches, buffers responses in a prefetch FIFO, feeds decode.
// Optional macro FETCH_BYPASS_EN: an unkilled response arriving at an empty FIFO is presented the same cycle.
module risc_toy_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IREQ,
    output logic [29:0] IADDR,
    input  logic [31:0] INSTR,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        FD_VALID,
    output logic [31:0] FD_INSTR,
    output logic [31:0] FD_PC,
    output logic [31:0] FD_NPC
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_pc_d    [DEPTH];

    logic          resp_ok;
    logic          fifo_empty;
    logic          bypass;
    logic          pop;
    logic          fifo_pop;
    logic          push;
    logic [CW-1:0] occupied;

    always_comb begin
        resp_ok    = inflight_q && !REDIRECT;
        fifo_empty = (count_q == '0);
        bypass     = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass     = fifo_empty && resp_ok;
`endif
        FD_VALID   = !fifo_empty || bypass;
        pop        = FD_VALID && !STALL;
        fifo_pop   = pop && !fifo_empty;
        // A bypassed word that decode takes this cycle never enters the FIFO.
        push       = resp_ok && !(bypass && pop);
        occupied   = count_q + CW'(inflight_q);
        IREQ       = !RST && !REDIRECT && ((occupied < DEPTH_C) || pop);
        IADDR      = pc_q[31:2];

        FD_INSTR = '0;
        FD_PC    = '0;
        FD_NPC   = '0;
        if (bypass) begin
            FD_INSTR = INSTR;
            FD_PC    = req_pc_q;
        end else if (!fifo_empty) begin
            FD_INSTR = fifo_instr_q[head_q];
            FD_PC    = fifo_pc_q[head_q];
        end
        if (FD_VALID) begin
            FD_NPC = FD_PC + 32'd4;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        inflight_d   = IREQ;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;

        if (REDIRECT) begin
            pc_d    = REDIRECT_PC & ~32'h3;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (IREQ) begin
                pc_d     = pc_q + 32'd4;
                req_pc_d = pc_q;
            end
            if (push) begin
                fifo_instr_d[tail_q] = INSTR;
                fifo_pc_d[tail_q]    = req_pc_q;
                tail_d               = tail_q + 1'b1;
            end
            if (fifo_pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q         <= RESET_PC & ~32'h3;
            req_pc_q     <= '0;
            inflight_q   <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            fifo_instr_q <= '{default: '0};
            fifo_pc_q    <= '{default: '0};
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            inflight_q   <= inflight_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

endmodule

// File: doc/risc_toy_ifetch.md
Name: risc_toy_ifetch

Overview:
- Instruction-fetch front end of the RISC_TOY pipeline; sits directly upstream of decode/execute.
- Drives the instruction-memory port (IREQ/IADDR/INSTR) and buffers returned words in a small prefetch FIFO.
- Presents one instruction per cycle to decode with PC and PC+4.
- Absorbs decode stalls without losing in-flight fetches; flushes on branch/jump redirect from execute.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; bits [1:0] ignored.
- DEPTH, 2, prefetch FIFO entries; legal values 2..8, power of two.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IREQ  out  1  instruction-memory request this cycle.
- IADDR  out  30  word address, PC[31:2].
- INSTR  in  32  memory read data; valid in the cycle after IREQ=1.
- STALL  in  1  decode cannot accept the head instruction this cycle.
- REDIRECT  in  1  one-cycle pulse from execute: taken branch/jump.
- REDIRECT_PC  in  32  target byte address; bits [1:0] forced to 0.
- FD_VALID  out  1  FD_INSTR/FD_PC/FD_NPC hold a valid instruction.
- FD_INSTR  out  32  instruction word.
- FD_PC  out  32  byte address of FD_INSTR.
- FD_NPC  out  32  FD_PC+4, wraps mod 2^32.

Behaviour:
- Reset, async on RST=1: PC=RESET_PC & ~3; FIFO empty; in-flight flag cleared; IREQ=0; FD_VALID=0; FD_INSTR/FD_PC/FD_NPC=0.
- Outputs whenever FD_VALID=0: FD_INSTR/FD_PC/FD_NPC drive 0.
- Memory protocol: IADDR=PC[31:2] at all times. A response is captured on the edge ending the cycle after IREQ=1. The memory never back-pressures.
- In-flight flag: set on the edge when IREQ=1. Cleared on the edge when its response is captured or killed.
- Pop: occurs when FD_VALID=1 and STALL=0.
- Credit: credit = DEPTH - count - inflight + pop.
- Issue: IREQ = !RST && !REDIRECT && credit>0. On issue, PC <= PC+4 (mod 2^32). The PC of the request travels with it into the FIFO entry.
- Push: a response arriving with the in-flight flag set, not killed, is pushed as {INSTR, req_pc}. Push and pop in the same cycle are legal when full or empty. Count is unchanged when both occur.
- FIFO state: head/tail pointers wrap modulo DEPTH. Overflow is impossible by the credit rule. Pop when empty is impossible by FD_VALID.
- Steady state: with STALL=0 and DEPTH>=2, throughput is 1 instruction/cycle. Latency IREQ -> FD_VALID is 2 cycles: response in cycle N+1, head visible in N+2.
- Stall: FD_* hold stable while STALL=1. Fetch continues until credit reaches 0, then IREQ=0.
- Redirect (priority over STALL and pop):
  - On the edge ending a REDIRECT=1 cycle: FIFO emptied, PC <= REDIRECT_PC & ~3.
  - Any response due next cycle is marked killed and discarded.
  - IREQ=0 during the REDIRECT cycle.
  - The first fetch at the target issues the next cycle.
  - FD_VALID=0 the cycle after REDIRECT.
  - A response arriving in the REDIRECT cycle itself is discarded.
- Back-to-back REDIRECT: the last one wins; each pulse restarts the sequence.
- Reset mid-operation: all state cleared immediately, including in-flight. A response arriving after RST falls is ignored, because the in-flight flag is clear.
- PC wrap: PC=32'hFFFF_FFFC fetches, then PC wraps to 0. FD_NPC of that entry is 0.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and an unkilled response arrives, it appears combinationally on FD_* that cycle with FD_VALID=1. If STALL=0 it is consumed and not pushed; if STALL=1 it is pushed. Latency IREQ -> FD_VALID becomes 1 cycle. Credit counts the bypassed pop.
- Undefined: no bypass; latency is 2 cycles as above.

Test Plan:
- Reset release with RESET_PC=0x100, STALL=0, memory returns addr-tagged words -> IREQ=1 next cycle with IADDR=0x40; FD_VALID in cycle 2; FD_PC sequence 0x100,0x104,0x108 one per cycle; FD_NPC=FD_PC+4.
- STALL held 5 cycles from steady state, DEPTH=2 -> IREQ drops after FIFO holds 2 entries plus in-flight resolves; FD_PC stays 0x108 throughout. On release: 0x108,0x10C,0x110 with no gap or duplicate.
- REDIRECT with REDIRECT_PC=0x203 while a request to 0x114 is in flight -> 0x114 response discarded; FD_VALID=0 one cycle; next IADDR=0x80; next FD_PC=0x200.
- REDIRECT asserted together with STALL=1 and a full FIFO -> FIFO flushed; stall ignored; fetch resumes at target.
- RESET_PC=0xFFFF_FFF8 -> FD_PC 0xFFFFFFF8, 0xFFFFFFFC, 0x0; FD_NPC of the 0xFFFFFFFC entry = 0x0.
- FETCH_BYPASS_EN defined, reset release -> FD_VALID=1 in cycle 1 with FD_PC=RESET_PC. RST pulsed mid-stream -> FD_VALID=0 and IREQ=0 asynchronously; restart at RESET_PC.
